axi_read_arbiter: RTL

- Shares the single AXI read channel between the instruction cache (S0, high priority) and the data cache (S1, low priority).
- Replaces the current OR-merge of the two caches' AR outputs with granted, one-transaction-at-a-time arbitration.
- Uses fixed priority with an anti-starvation counter, and routes R beats back to the granted cache only.
- Sits between the two cache_axi instances and the M_AXI read channels inside the MMU.

---
 rtl/axi_read_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/axi_read_arbiter.sv
// Purpose: arbitrates the single AXI read channel between I-cache (S0, high prio) and D-cache (S1).
// Latency: M_AXI_ARVALID one cycle after the requester AR handshake; R beats routed with zero latency.
// Backpressure: one read outstanding; AR fields held until M_AXI_ARREADY; RREADY is the owner's RREADY.
//
// Ports:
//   M_AXI_CLK / M_AXI_RSTN        clock, asynchronous active-low reset
//   S{0,1}_AR*                    requester address channels (ARREADY from this block)
//   S{0,1}_R*                     requester read-data channels (only the owner sees RVALID)
//   M_AXI_AR* / M_AXI_R*          shared master read channels; ARID carries the owner
//   BUSY, GRANT, LEN_ERR          status: not idle, current/last owner, sticky burst-length error
module axi_read_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  M_AXI_CLK,
    input  logic                  M_AXI_RSTN,
    // requester 0 (instruction cache)
    input  logic [ADDR_WIDTH-1:0] S0_ARADDR,
    input  logic [7:0]            S0_ARLEN,
    input  logic [2:0]            S0_ARSIZE,
    input  logic [1:0]            S0_ARBURST,
    input  logic                  S0_ARVALID,
    output logic                  S0_ARREADY,
    output logic [DATA_WIDTH-1:0] S0_RDATA,
    output logic [1:0]            S0_RRESP,
    output logic                  S0_RLAST,
    output logic                  S0_RVALID,
    input  logic                  S0_RREADY,
    // requester 1 (data cache)
    input  logic [ADDR_WIDTH-1:0] S1_ARADDR,
    input  logic [7:0]            S1_ARLEN,
    input  logic [2:0]            S1_ARSIZE,
    input  logic [1:0]            S1_ARBURST,
    input  logic                  S1_ARVALID,
    output logic                  S1_ARREADY,
    output logic [DATA_WIDTH-1:0] S1_RDATA,
    output logic [1:0]            S1_RRESP,
    output logic                  S1_RLAST,
    output logic                  S1_RVALID,
    input  logic                  S1_RREADY,
    // shared master read channels
    output logic                  M_AXI_ARID,
    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [7:0]            M_AXI_ARLEN,
    output logic [2:0]            M_AXI_ARSIZE,
    output logic [1:0]            M_AXI_ARBURST,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RLAST,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY,
    // status
    output logic                  BUSY,
    output logic                  GRANT,
    output logic                  LEN_ERR
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_t                r_state;
    logic [7:0]            r_starve_cnt;
    logic [7:0]            r_beat_cnt;
    logic                  r_grant;
    logic                  r_len_err;
    logic                  r_arvalid;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [7:0]            r_arlen;
    logic [2:0]            r_arsize;
    logic [1:0]            r_arburst;

    logic w_starved;
    logic w_any_req;
    logic w_win;
    logic w_accept;
    logic w_data;
    logic w_s0_sel;
    logic w_s1_sel;
    logic w_r_hs;

    // Winner: 1 selects S1. S1 wins when starved or when S0 is not asking.
    assign w_starved = S1_ARVALID && (r_starve_cnt == LIMIT);
    assign w_any_req = S0_ARVALID || S1_ARVALID;
    assign w_win     = w_starved || !S0_ARVALID;

    // Handshake/routing strobes are gated by reset so nothing is offered while it is held.
    assign w_accept   = M_AXI_RSTN && (r_state == IDLE) && w_any_req;
    assign S0_ARREADY = w_accept && !w_win;
    assign S1_ARREADY = w_accept && w_win;

    assign w_data   = M_AXI_RSTN && (r_state == DATA);
    assign w_s0_sel = w_data && !r_grant;
    assign w_s1_sel = w_data && r_grant;

    assign M_AXI_RREADY = (w_s0_sel && S0_RREADY) || (w_s1_sel && S1_RREADY);
    assign w_r_hs       = M_AXI_RVALID && M_AXI_RREADY;

    assign S0_RVALID = w_s0_sel && M_AXI_RVALID;
    assign S0_RDATA  = w_s0_sel ? M_AXI_RDATA : '0;
    assign S0_RRESP  = w_s0_sel ? M_AXI_RRESP : 2'b00;
    assign S0_RLAST  = w_s0_sel && M_AXI_RLAST;
    assign S1_RVALID = w_s1_sel && M_AXI_RVALID;
    assign S1_RDATA  = w_s1_sel ? M_AXI_RDATA : '0;
    assign S1_RRESP  = w_s1_sel ? M_AXI_RRESP : 2'b00;
    assign S1_RLAST  = w_s1_sel && M_AXI_RLAST;

    assign M_AXI_ARID    = r_grant;
    assign M_AXI_ARADDR  = r_araddr;
    assign M_AXI_ARLEN   = r_arlen;
    assign M_AXI_ARSIZE  = r_arsize;
    assign M_AXI_ARBURST = r_arburst;
    assign M_AXI_ARVALID = r_arvalid;
    assign BUSY          = (r_state != IDLE);
    assign GRANT         = r_grant;
    assign LEN_ERR       = r_len_err;

    always_ff @(posedge M_AXI_CLK or negedge M_AXI_RSTN) begin
        if (!M_AXI_RSTN) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_beat_cnt   <= '0;
            r_grant      <= 1'b0;
            r_len_err    <= 1'b0;
            r_arvalid    <= 1'b0;
            r_araddr     <= '0;
            r_arlen      <= '0;
            r_arsize     <= '0;
            r_arburst    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_grant   <= w_win;
                        r_araddr  <= w_win ? S1_ARADDR  : S0_ARADDR;
                        r_arlen   <= w_win ? S1_ARLEN   : S0_ARLEN;
                        r_arsize  <= w_win ? S1_ARSIZE  : S0_ARSIZE;
                        r_arburst <= w_win ? S1_ARBURST : S0_ARBURST;
                        r_arvalid <= 1'b1;
                        r_state   <= ADDR;
                        // Count only S0 grants that made a waiting S1 wait longer.
                        if (!w_win && S1_ARVALID)
                            r_starve_cnt <= (r_starve_cnt == LIMIT) ? LIMIT : r_starve_cnt + 8'd1;
                        else
                            r_starve_cnt <= '0;
                    end
                end
                ADDR: begin
                    if (M_AXI_ARREADY) begin
                        r_arvalid  <= 1'b0;
                        r_beat_cnt <= r_arlen;
                        r_state    <= DATA;
                    end
                end
                DATA: begin
                    if (w_r_hs) begin
                        if (r_beat_cnt != 8'd0)
                            r_beat_cnt <= r_beat_cnt - 8'd1;
                        // beat_cnt reaches 0 exactly on the beat that should carry RLAST.
                        if (M_AXI_RLAST) begin
                            if (r_beat_cnt != 8'd0)
                                r_len_err <= 1'b1;
                            r_state <= IDLE;
                        end else if (r_beat_cnt == 8'd0) begin
                            r_len_err <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
